// File: rtl/lilypad_ride_tracker.sv
// Tracks whether the frog is riding one lilypad and reports the pad's carry
// motion. It also detects drowning after a grace window spent off-pad in the river.
module lilypad_ride_tracker #(
  parameter logic [10:0] RIVER_Y_TOP  = 11'd40,
  parameter logic [10:0] RIVER_Y_BOT  = 11'd240,
  parameter logic [3:0]  GRACE_FRAMES = 4'd3,
  parameter logic [10:0] MAX_STEP     = 11'd16
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [10:0] FrogX,
  input  logic [10:0] FrogY,
  input  logic [10:0] Frog_Size,
  input  logic [10:0] LPadX,
  input  logic [10:0] LPadY,
  input  logic [10:0] LPad_Width,
  input  logic [10:0] LPad_Height,
  input  logic        Frog_Respawn,
  output logic        On_Pad,
  output logic [10:0] Carry_Motion,
  output logic        Drowned,
  output logic [1:0]  Ride_State
);

  typedef enum logic [1:0] {
    DRY    = 2'b00,
    RIDE   = 2'b01,
    GRACE  = 2'b10,
    SPLASH = 2'b11
  } ride_state_e;

  ride_state_e state_q, state_d;
  logic [3:0]  grace_cnt_q, grace_cnt_d;
  logic [10:0] prev_x_q;
  logic        on_pad_q, on_pad_d;
  logic [10:0] carry_q, carry_d;
  logic        drowned_q, drowned_d;

  logic signed [11:0] frog_x_s, frog_y_s, pad_x_s, pad_y_s;
  logic signed [11:0] half_s, cx_s, cy_s, pad_x_end_s, pad_y_end_s;
  logic        [11:0] size_ext;
  logic               hit, in_river;

  logic [10:0] diff, diff_mag, delta;

  assign frog_x_s    = {FrogX[10], FrogX};
  assign frog_y_s    = {FrogY[10], FrogY};
  assign pad_x_s     = {LPadX[10], LPadX};
  assign pad_y_s     = {LPadY[10], LPadY};
  assign size_ext    = {1'b0, Frog_Size};
  assign half_s      = size_ext >> 1;
  assign cx_s        = frog_x_s + half_s;
  assign cy_s        = frog_y_s + half_s;
  assign pad_x_end_s = pad_x_s + {1'b0, LPad_Width};
  assign pad_y_end_s = pad_y_s + {1'b0, LPad_Height};

  assign hit = (cx_s >= pad_x_s) && (cx_s < pad_x_end_s) &&
               (cy_s >= pad_y_s) && (cy_s < pad_y_end_s);

  assign in_river = (FrogY >= RIVER_Y_TOP) && (FrogY < RIVER_Y_BOT);

  // A displacement larger than MAX_STEP is the pad wrapping across the screen edge.
  assign diff     = LPadX - prev_x_q;
  assign diff_mag = diff[10] ? (~diff + 11'd1) : diff;
  assign delta    = (diff_mag > MAX_STEP) ? '0 : diff;

  always_comb begin
    state_d     = state_q;
    grace_cnt_d = grace_cnt_q;
    unique case (state_q)
      DRY: begin
        if (in_river && hit) begin
          state_d = RIDE;
        end else if (in_river) begin
          state_d     = GRACE;
          grace_cnt_d = 4'd1;
        end
      end
      RIDE: begin
        if (!in_river) begin
          state_d = DRY;
        end else if (!hit) begin
          state_d     = GRACE;
          grace_cnt_d = 4'd1;
        end
      end
      GRACE: begin
        if (!in_river) begin
          state_d     = DRY;
          grace_cnt_d = '0;
        end else if (hit) begin
          state_d     = RIDE;
          grace_cnt_d = '0;
        end else if (grace_cnt_q == GRACE_FRAMES) begin
          state_d = SPLASH;
        end else begin
          grace_cnt_d = grace_cnt_q + 4'd1;
        end
      end
      SPLASH: begin
        if (Frog_Respawn) begin
          state_d     = DRY;
          grace_cnt_d = '0;
        end
      end
      default: begin
        state_d     = DRY;
        grace_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    on_pad_d  = (state_d == RIDE);
    carry_d   = (state_d == RIDE) ? delta : '0;
    drowned_d = (state_q == GRACE) && (state_d == SPLASH);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= DRY;
      grace_cnt_q <= '0;
      prev_x_q    <= LPadX;
      on_pad_q    <= 1'b0;
      carry_q     <= '0;
      drowned_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grace_cnt_q <= grace_cnt_d;
      prev_x_q    <= LPadX;
      on_pad_q    <= on_pad_d;
      carry_q     <= carry_d;
      drowned_q   <= drowned_d;
    end
  end

  assign On_Pad       = on_pad_q;
  assign Carry_Motion = carry_q;
  assign Drowned      = drowned_q;
  assign Ride_State   = state_q;

endmodule

// File: tb/tb_lilypad_ride_tracker.sv
module tb_lilypad_ride_tracker;

  logic        frame_clk;
  logic        Reset;
  logic [10:0] FrogX, FrogY, Frog_Size;
  logic [10:0] LPadX, LPadY, LPad_Width, LPad_Height;
  logic        Frog_Respawn;
  logic        On_Pad;
  logic [10:0] Carry_Motion;
  logic        Drowned;
  logic [1:0]  Ride_State;

  int unsigned checks = 0;
  int unsigned passed = 0;

  typedef struct {
    logic [1:0]  st;
    logic        on;
    logic [10:0] cm;
    logic        dr;
    string       tag;
  } exp_t;

  exp_t sb[$];

  lilypad_ride_tracker #(
    .RIVER_Y_TOP (11'd40),
    .RIVER_Y_BOT (11'd240),
    .GRACE_FRAMES(4'd3),
    .MAX_STEP    (11'd16)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .FrogX       (FrogX),
    .FrogY       (FrogY),
    .Frog_Size   (Frog_Size),
    .LPadX       (LPadX),
    .LPadY       (LPadY),
    .LPad_Width  (LPad_Width),
    .LPad_Height (LPad_Height),
    .Frog_Respawn(Frog_Respawn),
    .On_Pad      (On_Pad),
    .Carry_Motion(Carry_Motion),
    .Drowned     (Drowned),
    .Ride_State  (Ride_State)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input string field,
                     input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
  endtask

  // Drive one frame of inputs, queue the expected registered outputs, then
  // compare them just after the capturing edge.
  task automatic step(input logic rst, input logic resp,
                      input logic [10:0] fx, input logic [10:0] fy,
                      input logic [10:0] px,
                      input logic [1:0] st, input logic on,
                      input logic [10:0] cm, input logic dr,
                      input string tag);
    exp_t e;
    Reset        = rst;
    Frog_Respawn = resp;
    FrogX        = fx;
    FrogY        = fy;
    LPadX        = px;
    sb.push_back('{st: st, on: on, cm: cm, dr: dr, tag: tag});
    @(posedge frame_clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "Ride_State",   {9'd0, Ride_State}, {9'd0, e.st});
    chk(e.tag, "On_Pad",       {10'd0, On_Pad},    {10'd0, e.on});
    chk(e.tag, "Carry_Motion", Carry_Motion,       e.cm);
    chk(e.tag, "Drowned",      {10'd0, Drowned},   {10'd0, e.dr});
  endtask

  initial begin
    Reset        = 1'b0;
    Frog_Respawn = 1'b0;
    FrogX        = 11'd100;
    FrogY        = 11'd300;
    Frog_Size    = 11'd40;
    LPadX        = 11'd0;
    LPadY        = 11'd100;
    LPad_Width   = 11'd40;
    LPad_Height  = 11'd40;

    // Reset and idle on dry land
    step(1, 0, 11'd100, 11'd300, 11'd0, 2'b00, 0, 11'd0, 0, "reset");
    for (int i = 0; i < 5; i++)
      step(0, 0, 11'd100, 11'd300, 11'd0, 2'b00, 0, 11'd0, 0, "dry_idle");

    // Boarding a pad that jumped 100 px: ride, but the jump is a wrap
    step(0, 0, 11'd110, 11'd100, 11'd100, 2'b01, 1, 11'd0,     0, "board");
    step(0, 0, 11'd100, 11'd100, 11'd90,  2'b01, 1, 11'h7F6,   0, "move_m10_a");
    step(0, 0, 11'd100, 11'd100, 11'd90,  2'b01, 1, 11'd0,     0, "idle_a");
    step(0, 0, 11'd90,  11'd100, 11'd80,  2'b01, 1, 11'h7F6,   0, "move_m10_b");
    step(0, 0, 11'd90,  11'd100, 11'd80,  2'b01, 1, 11'd0,     0, "idle_b");
    step(0, 0, 11'd80,  11'd100, 11'd70,  2'b01, 1, 11'h7F6,   0, "move_m10_c");

    // Positive motion and wrap across the screen edge
    step(0, 0, 11'd640,  11'd100, 11'd630,  2'b01, 1, 11'd0,   0, "jump_630");
    step(0, 0, 11'd650,  11'd100, 11'd640,  2'b01, 1, 11'd10,  0, "move_p10_a");
    step(0, 0, 11'd1978, 11'd100, 11'd1968, 2'b01, 1, 11'd0,   0, "wrap_frame");
    step(0, 0, 11'd1988, 11'd100, 11'd1978, 2'b01, 1, 11'd10,  0, "move_p10_b");
    step(0, 0, 11'd2004, 11'd100, 11'd1994, 2'b01, 1, 11'd16,  0, "step_p16");
    step(0, 0, 11'd2021, 11'd100, 11'd2011, 2'b01, 1, 11'd0,   0, "step_p17");
    step(0, 0, 11'd2005, 11'd100, 11'd1995, 2'b01, 1, 11'h7F0, 0, "step_m16");

    // Leave the river, then drown off-pad; pad motion must not leak out
    step(0, 0, 11'd300, 11'd300, 11'd900, 2'b00, 0, 11'd0, 0, "exit_river");
    step(0, 0, 11'd300, 11'd100, 11'd905, 2'b10, 0, 11'd0, 0, "grace1");
    step(0, 0, 11'd300, 11'd100, 11'd910, 2'b10, 0, 11'd0, 0, "grace2");
    step(0, 0, 11'd300, 11'd100, 11'd915, 2'b10, 0, 11'd0, 0, "grace3");
    step(0, 0, 11'd300, 11'd100, 11'd920, 2'b11, 0, 11'd0, 1, "splash");
    step(0, 0, 11'd300, 11'd100, 11'd925, 2'b11, 0, 11'd0, 0, "splash_hold");
    step(0, 0, 11'd920, 11'd100, 11'd930, 2'b11, 0, 11'd0, 0, "splash_on_pad");

    // Respawn leaves SPLASH; a second respawn in DRY does nothing
    step(0, 1, 11'd300, 11'd400, 11'd930, 2'b00, 0, 11'd0, 0, "respawn");
    step(0, 1, 11'd300, 11'd400, 11'd930, 2'b00, 0, 11'd0, 0, "respawn_dry");

    // Hit on the expiry frame wins over drowning
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "hx_grace1");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "hx_grace2");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "hx_grace3");
    step(0, 0, 11'd920, 11'd100, 11'd930, 2'b01, 1, 11'd0, 0, "hx_rescue");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "fall_off");
    step(0, 0, 11'd300, 11'd300, 11'd930, 2'b00, 0, 11'd0, 0, "grace_ashore");

    // Reset mid-GRACE: no pulse, full window needed again
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "rg_grace1");
    step(1, 0, 11'd300, 11'd100, 11'd930, 2'b00, 0, 11'd0, 0, "rg_reset");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "rg_again1");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "rg_again2");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b10, 0, 11'd0, 0, "rg_again3");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b11, 0, 11'd0, 1, "rg_splash");
    step(0, 0, 11'd300, 11'd100, 11'd930, 2'b11, 0, 11'd0, 0, "rg_hold");

    // Reset wins over a coincident respawn
    step(1, 1, 11'd300, 11'd100, 11'd930, 2'b00, 0, 11'd0, 0, "rst_over_resp");
    step(0, 0, 11'd300, 11'd300, 11'd930, 2'b00, 0, 11'd0, 0, "post_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
